serial_word_collector: RTL

- Downstream stage of the parameterized shift register: consumes its serial `shiftout` stream one qualified bit per cycle.
- Reassembles the bits into WORD_WIDTH-bit parallel words.
- Presents each word on a valid/ready output with a one-entry holding buffer, so collection continues while the consumer stalls.
- Tracks framing and flags dropped words.

---
 rtl/serial_word_collector.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with a one-entry valid/ready holding buffer.
// Optional even-parity trailer bit enabled by `define SERIAL_COLLECTOR_PARITY_EN.
module serial_word_collector #(
  parameter int WORD_WIDTH      = 8,
  parameter     SHIFT_DIRECTION = "LEFT",
  parameter bit CONTINUOUS      = 1'b1
) (
  input  logic                                clock,
  input  logic                                aclr_n,
  input  logic                                sclr,
  input  logic                                bit_valid,
  input  logic                                serial_in,
  input  logic                                frame_start,
  output logic [WORD_WIDTH-1:0]               word_data,
  output logic                                word_valid,
  input  logic                                word_ready,
  output logic                                word_perr,
  output logic [$clog2(WORD_WIDTH+2)-1:0]     bit_count,
  output logic                                overflow,
  output logic                                busy
);

  localparam int CW = $clog2(WORD_WIDTH+2);
  localparam bit RIGHT = (SHIFT_DIRECTION == "RIGHT");
`ifdef SERIAL_COLLECTOR_PARITY_EN
  localparam int LAST = WORD_WIDTH + 1;
`else
  localparam int LAST = WORD_WIDTH;
`endif

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WORD_WIDTH-1:0] r_acc;
  logic [WORD_WIDTH-1:0] w_acc_nxt;
  logic [WORD_WIDTH-1:0] w_acc_base;
  logic [WORD_WIDTH-1:0] w_acc_sh;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [CW-1:0]         w_cnt_base;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_cap;
  logic                  w_done;
  logic                  w_data_bit;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_perr;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr;
  logic                  r_ovf;

  // frame_start restarts the word from an empty accumulator
  assign w_acc_base = frame_start ? '0 : r_acc;
  assign w_cnt_base = frame_start ? '0 : r_cnt;
  assign w_cnt_inc  = w_cnt_base + 1'b1;
  assign w_cap      = bit_valid & (frame_start | (r_state == COLLECT));
  assign w_done     = w_cap & (w_cnt_inc == CW'(LAST));
  assign w_data_bit = (w_cnt_base < CW'(WORD_WIDTH));
  assign w_acc_sh   = RIGHT ? {serial_in, w_acc_base[WORD_WIDTH-1:1]}
                            : {w_acc_base[WORD_WIDTH-2:0], serial_in};

`ifdef SERIAL_COLLECTOR_PARITY_EN
  assign w_word = w_acc_base;
  assign w_perr = (^w_acc_base) ^ serial_in;
`else
  assign w_word = w_acc_sh;
  assign w_perr = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    if (frame_start) begin
      w_state_nxt = COLLECT;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
    end
    if (w_cap) begin
      w_cnt_nxt = w_cnt_inc;
      if (w_data_bit) w_acc_nxt = w_acc_sh;
      if (w_done) begin
        w_cnt_nxt   = '0;
        w_state_nxt = CONTINUOUS ? COLLECT : IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (sclr) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_done) begin
        // a transfer on this edge frees the buffer for the new word
        if (!r_valid || word_ready) begin
          r_data  <= w_word;
          r_perr  <= w_perr;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && word_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign word_data  = r_data;
  assign word_valid = r_valid;
  assign word_perr  = r_perr;
  assign bit_count  = r_cnt;
  assign overflow   = r_ovf;
  assign busy       = (r_state == COLLECT);

endmodule
